aes_job_sequencer: RTL and testbench

Sequencing controller between a block-request interface and the AES-256 datapath (Key_Expansion + Encryption_Core). It accepts one (key, block) job at a time over a valid/ready handshake and caches the expanded key, so Key_Expansion runs only when the key changes. It then pulses Encryption_Core, captures the ciphertext and returns it over a valid/ready result handshake, with optional CBC chaining and a watchdog on both cores.

---
 rtl/aes_job_sequencer.sv | 169 ++++++++++++++++
 tb/tb_aes_job_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_job_sequencer.sv
// Job sequencer between a block-request handshake and the AES-256 key-expansion / encryption cores.
// Caches the expanded key, handles optional CBC chaining and aborts a job if a core never finishes.
module aes_job_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [255:0] in_key_i,
    input  logic [127:0] in_data_i,
    input  logic         in_cbc_i,
    input  logic         in_iv_load_i,
    input  logic [127:0] in_iv_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         out_err_o,
    output logic         key_cached_o,
    output logic         ke_start_o,
    output logic [255:0] ke_key_o,
    input  logic         ke_fin_i,
    output logic         enc_start_o,
    output logic [127:0] enc_plain_o,
    input  logic [127:0] enc_cipher_i,
    input  logic         enc_fin_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, KEY_START, KEY_WAIT, ENC_START, ENC_WAIT, OUT_HOLD
    } state_t;

    state_t         state_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [127:0]   out_data_q;
    logic           out_err_q;
    logic           key_cached_q;
    logic           ke_start_q;
    logic [255:0]   ke_key_q;
    logic           enc_start_q;
    logic [127:0]   enc_plain_q;
    logic [127:0]   chain_q;
    logic           mode_q;
    logic [CW-1:0]  cnt_q;
    logic           ke_fin_q;
    logic           enc_fin_q;

    logic           ke_edge;
    logic           enc_edge;
    logic           wd_expired;
    logic           key_hit;
    logic [127:0]   chain_src;

    assign ke_edge    = ke_fin_i && !ke_fin_q;
    assign enc_edge   = enc_fin_i && !enc_fin_q;
    assign wd_expired = (cnt_q == CW'(TIMEOUT - 1));
    assign key_hit    = key_cached_q && (in_key_i == ke_key_q);
    assign chain_src  = in_iv_load_i ? in_iv_i : chain_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_err_q    <= 1'b0;
            key_cached_q <= 1'b0;
            ke_start_q   <= 1'b0;
            ke_key_q     <= '0;
            enc_start_q  <= 1'b0;
            enc_plain_q  <= '0;
            chain_q      <= '0;
            mode_q       <= 1'b0;
            cnt_q        <= '0;
            ke_fin_q     <= 1'b0;
            enc_fin_q    <= 1'b0;
        end else begin
            ke_fin_q    <= ke_fin_i;
            enc_fin_q   <= enc_fin_i;
            ke_start_q  <= 1'b0;
            enc_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_q) begin
                        ke_key_q    <= in_key_i;
                        enc_plain_q <= in_cbc_i ? (in_data_i ^ chain_src) : in_data_i;
                        mode_q      <= in_cbc_i;
                        out_err_q   <= 1'b0;
                        in_ready_q  <= 1'b0;
                        if (key_hit) begin
                            state_q     <= ENC_START;
                            enc_start_q <= 1'b1;
                        end else begin
                            state_q    <= KEY_START;
                            ke_start_q <= 1'b1;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                KEY_START: begin
                    key_cached_q <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= KEY_WAIT;
                end
                KEY_WAIT: begin
                    // A finish edge in the expiry cycle still counts as success.
                    if (ke_edge) begin
                        key_cached_q <= 1'b1;
                        enc_start_q  <= 1'b1;
                        state_q      <= ENC_START;
                    end else if (wd_expired) begin
                        out_err_q    <= 1'b1;
                        out_data_q   <= '0;
                        key_cached_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= OUT_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ENC_START: begin
                    cnt_q   <= '0;
                    state_q <= ENC_WAIT;
                end
                ENC_WAIT: begin
                    if (enc_edge) begin
                        out_data_q  <= enc_cipher_i;
                        if (mode_q) begin
                            chain_q <= enc_cipher_i;
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= OUT_HOLD;
                    end else if (wd_expired) begin
                        out_err_q    <= 1'b1;
                        out_data_q   <= '0;
                        key_cached_q <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= OUT_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                OUT_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_err_o    = out_err_q;
    assign key_cached_o = key_cached_q;
    assign ke_start_o   = ke_start_q;
    assign ke_key_o     = ke_key_q;
    assign enc_start_o  = enc_start_q;
    assign enc_plain_o  = enc_plain_q;
endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer with stub key-expansion and encryption cores.
module tb_aes_job_sequencer;
    localparam int TO = 8;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY2     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e20;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT2      = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] PT3      = 128'h0f0e0d0c0b0a09080706050403020100;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_cbc, in_iv_load;
    logic [255:0] in_key;
    logic [127:0] in_data, in_iv;
    logic         out_valid, out_ready, out_err, key_cached;
    logic [127:0] out_data;
    logic         ke_start, ke_fin, enc_start, enc_fin;
    logic [255:0] ke_key;
    logic [127:0] enc_plain, enc_cipher;

    int n_tests = 0;
    int n_fail  = 0;

    aes_job_sequencer #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_key_i(in_key), .in_data_i(in_data),
        .in_cbc_i(in_cbc), .in_iv_load_i(in_iv_load), .in_iv_i(in_iv),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_err_o(out_err), .key_cached_o(key_cached),
        .ke_start_o(ke_start), .ke_key_o(ke_key), .ke_fin_i(ke_fin),
        .enc_start_o(enc_start), .enc_plain_o(enc_plain),
        .enc_cipher_i(enc_cipher), .enc_fin_i(enc_fin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Stand-in for the encryption core: the FIPS-197 vector, otherwise a keyed XOR.
    function automatic logic [127:0] stub_enc(input logic [255:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return p ^ k[255:128] ^ ~k[127:0];
    endfunction

    int ke_cnt  = 0;
    int enc_cnt = 0;
    int enc_dly = 4;
    bit enc_stuck = 0;

    initial begin
        ke_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ke_cnt = 0; ke_fin = 1'b0;
            end else if (ke_start) begin
                ke_cnt = 1;
            end else if (ke_cnt != 0) begin
                ke_cnt++;
                if (ke_cnt == 4) ke_fin = 1'b1;
                if (ke_cnt >= 6) begin ke_fin = 1'b0; ke_cnt = 0; end
            end
        end
    end

    initial begin
        enc_fin = 1'b0; enc_cipher = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                enc_cnt = 0; enc_fin = 1'b0;
            end else if (enc_start) begin
                enc_cnt = 1;
            end else if (enc_cnt != 0) begin
                enc_cnt++;
                if (enc_cnt == enc_dly && !enc_stuck) begin
                    enc_cipher = stub_enc(ke_key, enc_plain);
                    enc_fin = 1'b1;
                end
                if (enc_cnt >= enc_dly + 2) begin enc_fin = 1'b0; enc_cnt = 0; end
            end
        end
    end

    int           r_nke, r_nenc, r_enc_cyc, r_valid_cyc;
    logic [127:0] r_plain, r_data;
    logic         r_err, r_cached, r_stable, r_busy_ok, r_ready_after, r_got;

    // Accept one job, observe it to completion, optionally stall the result for 'hold' cycles.
    task automatic run_job(input logic [255:0] k, input logic [127:0] pt, input logic cbc,
                           input logic ivl, input logic [127:0] iv, input int hold);
        int c;
        int w;
        r_nke = 0; r_nenc = 0; r_enc_cyc = -1; r_valid_cyc = -1;
        r_plain = '0; r_stable = 1'b1; r_busy_ok = 1'b1; r_got = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        check("ready_before_job", {255'd0, in_ready}, 256'd1);
        in_key = k; in_data = pt; in_cbc = cbc; in_iv_load = ivl; in_iv = iv;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c = 1;
        while (!out_valid && c < 100) begin
            if (ke_start) r_nke++;
            if (enc_start) begin r_nenc++; r_enc_cyc = c; r_plain = enc_plain; end
            if (in_ready) r_busy_ok = 1'b0;
            @(negedge clk);
            c++;
        end
        if (!out_valid) begin
            check("result_timeout", 256'd0, 256'd1);
            return;
        end
        r_got = 1'b1;
        r_valid_cyc = c;
        r_data = out_data; r_err = out_err; r_cached = key_cached;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== r_data || out_err !== r_err || in_ready !== 1'b0)
                r_stable = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        r_ready_after = in_ready;
        $display("[TB] job key=..%h pt=%h -> data=%h err=%0d ke=%0d enc=%0d valid@%0d",
                 k[15:0], pt, r_data, r_err, r_nke, r_nenc, r_valid_cyc);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_key = '0; in_data = '0; in_cbc = 1'b0; in_iv_load = 1'b0; in_iv = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {255'd0, in_ready}, 256'd0);
        check("rst_outputs", {out_valid, out_err, key_cached, ke_start, enc_start, out_data}, 256'd0);
        check("rst_ke_key", ke_key, 256'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {255'd0, in_ready}, 256'd1);

        // Cold start with the FIPS-197 vector
        run_job(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, '0, 0);
        check("cold_ke_starts", r_nke, 1);
        check("cold_enc_starts", r_nenc, 1);
        check("cold_plain", r_plain, FIPS_PT);
        check("cold_data", r_data, FIPS_CT);
        check("cold_err", r_err, 0);
        check("cold_cached", r_cached, 1);
        check("cold_busy", r_busy_ok, 1);
        check("ready_after_handshake", r_ready_after, 1);

        // Same key: cached, enc_start right after acceptance, result one cycle after fin edge
        run_job(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, '0, 0);
        check("hit_ke_starts", r_nke, 0);
        check("hit_enc_cycle", r_enc_cyc, 1);
        check("hit_valid_cycle", r_valid_cyc, 5);
        check("hit_data", r_data, FIPS_CT);
        check("hit_cached", r_cached, 1);

        // Key change and revert
        run_job(KEY2, FIPS_PT, 1'b0, 1'b0, '0, 0);
        check("key2_ke_starts", r_nke, 1);
        check("key2_data", r_data, stub_enc(KEY2, FIPS_PT));
        run_job(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, '0, 0);
        check("revert_ke_starts", r_nke, 1);
        check("revert_data", r_data, FIPS_CT);

        // CBC: IV of zero, then an interleaved ECB job, then a chained job
        run_job(FIPS_KEY, FIPS_PT, 1'b1, 1'b1, '0, 0);
        check("cbc1_plain", r_plain, FIPS_PT);
        check("cbc1_data", r_data, FIPS_CT);
        run_job(FIPS_KEY, PT3, 1'b0, 1'b0, '0, 0);
        check("ecb_mid_data", r_data, stub_enc(FIPS_KEY, PT3));
        run_job(FIPS_KEY, PT2, 1'b1, 1'b0, '0, 0);
        check("cbc2_plain", r_plain, PT2 ^ FIPS_CT);
        check("cbc2_data", r_data, stub_enc(FIPS_KEY, PT2 ^ FIPS_CT));

        // Finish edge on the last permitted wait cycle beats the watchdog
        enc_dly = TO + 1;
        run_job(FIPS_KEY, PT3, 1'b0, 1'b0, '0, 0);
        check("edge_wins_err", r_err, 0);
        check("edge_wins_data", r_data, stub_enc(FIPS_KEY, PT3));
        check("edge_wins_cycle", r_valid_cyc, TO + 2);
        enc_dly = 4;

        // Watchdog on a stuck encryption core
        enc_stuck = 1;
        run_job(FIPS_KEY, PT2, 1'b0, 1'b0, '0, 0);
        check("wd_err", r_err, 1);
        check("wd_data", r_data, 0);
        check("wd_cached", r_cached, 0);
        check("wd_cycle", r_valid_cyc, TO + 2);
        enc_stuck = 0;
        run_job(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, '0, 0);
        check("wd_rekey_ke_starts", r_nke, 1);
        check("wd_rekey_data", r_data, FIPS_CT);
        check("wd_rekey_err", r_err, 0);

        // Backpressure: result held for 20 cycles
        run_job(FIPS_KEY, PT3, 1'b0, 1'b0, '0, 20);
        check("stall_stable", r_stable, 1);
        check("stall_data", r_data, stub_enc(FIPS_KEY, PT3));

        // Reset during KEY_WAIT
        in_key = KEY2; in_data = PT2; in_cbc = 1'b0; in_iv_load = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_ke_start", {255'd0, ke_start}, 256'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {in_ready, out_valid, out_err, key_cached, ke_start, enc_start, out_data}, 256'd0);
        check("midrst_ke_key", ke_key, 256'd0);
        check("midrst_plain", {128'd0, enc_plain}, 256'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_job(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, '0, 0);
        check("postrst_ke_starts", r_nke, 1);
        check("postrst_data", r_data, FIPS_CT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
